// File: rtl/instruction_decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// instruction_decode_stage_pkg
// Shared widths, bundle bit positions, opcode constants and the BOOT/RUN
// state encoding for the IF<->ID decode stage.
// Optional feature macro used by the stage: IF_ID_JUMP_EN.
// -----------------------------------------------------------------------------
package instruction_decode_stage_pkg;

    localparam int unsigned PC_W        = 8;
    localparam int unsigned INSTR_W     = 16;
    localparam int unsigned IF_BUNDLE_W = 24;
    localparam int unsigned BR_BUNDLE_W = 9;

    // Fetch bundle: [7:0] pc, [23:8] instruction
    localparam int unsigned IF_PC_LSB    = 0;
    localparam int unsigned IF_PC_MSB    = 7;
    localparam int unsigned IF_INSTR_LSB = 8;
    localparam int unsigned IF_INSTR_MSB = 23;

    // Redirect bundle: [8] redirect/taken, [7:0] target
    localparam int unsigned BR_TGT_LSB = 0;
    localparam int unsigned BR_TGT_MSB = 7;
    localparam int unsigned BR_VLD_BIT = 8;

    localparam logic [3:0] OPC_JMP = 4'hF;

    typedef enum logic {
        StBoot = 1'b0,
        StRun  = 1'b1
    } id_state_e;

    function automatic logic [BR_BUNDLE_W-1:0] br_pack(input logic vld,
                                                       input logic [PC_W-1:0] tgt);
        return {vld, tgt};
    endfunction

endpackage

// File: rtl/instruction_decode_stage_field_decode.sv
// -----------------------------------------------------------------------------
// instr_field_decode
// Purely combinational split of a 16-bit instruction into its fields.
// Ports:
//   i_instr   in  16  raw instruction
//   o_opcode  out 4   instr[15:12]
//   o_rd      out 4   instr[11:8]
//   o_rs      out 4   instr[7:4]
//   o_rt      out 4   instr[3:0]
//   o_imm8    out 8   instr[7:0]
// -----------------------------------------------------------------------------
module instr_field_decode
    import instruction_decode_stage_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    output logic [3:0]         o_opcode,
    output logic [3:0]         o_rd,
    output logic [3:0]         o_rs,
    output logic [3:0]         o_rt,
    output logic [7:0]         o_imm8
);

    assign o_opcode = i_instr[15:12];
    assign o_rd     = i_instr[11:8];
    assign o_rs     = i_instr[7:4];
    assign o_rt     = i_instr[3:0];
    assign o_imm8   = i_instr[7:0];

endmodule

// File: rtl/instruction_decode_stage.sv
// -----------------------------------------------------------------------------
// instruction_decode_stage
// Holds one instruction in the ID pipeline register, presents its fields
// downstream with valid/ready, and steers the fetch unit purely through the
// redirect bundle (fetch has no stall or reset input of its own).
// Optional feature: define IF_ID_JUMP_EN to resolve JMP (opcode 4'hF) in ID.
// Parameters:
//   RESET_PC            PC fetch is pinned to during and right after reset
// Ports:
//   i_clk               clock, rising edge
//   i_rst_n             asynchronous active-low reset
//   i_if_data      [23:0] fetch bundle {instr, pc}
//   i_ex_branch_update [8:0] execute redirect {taken, target}
//   o_branch_update [8:0] redirect to fetch {redirect, target}
//   i_id_ready          downstream accepts the ID instruction
//   o_id_valid          ID register holds a valid instruction
//   o_id_pc, o_id_opcode, o_id_rd, o_id_rs, o_id_rt, o_id_imm8  decoded fields
// -----------------------------------------------------------------------------
module instruction_decode_stage
    import instruction_decode_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'd0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [IF_BUNDLE_W-1:0] i_if_data,
    input  logic [BR_BUNDLE_W-1:0] i_ex_branch_update,
    output logic [BR_BUNDLE_W-1:0] o_branch_update,
    input  logic                   i_id_ready,
    output logic                   o_id_valid,
    output logic [PC_W-1:0]        o_id_pc,
    output logic [3:0]             o_id_opcode,
    output logic [3:0]             o_id_rd,
    output logic [3:0]             o_id_rs,
    output logic [3:0]             o_id_rt,
    output logic [7:0]             o_id_imm8
);

    id_state_e             r_state;
    logic                  r_valid;
    logic [PC_W-1:0]       r_pc;
    logic [INSTR_W-1:0]    r_instr;

    logic                  w_ex_taken;
    logic                  w_accept;
    logic                  w_jmp;
    logic [BR_BUNDLE_W-1:0] w_br;
    logic [3:0]            w_opcode;
    logic [7:0]            w_imm8;

    instr_field_decode u_field_decode (
        .i_instr  (r_instr),
        .o_opcode (w_opcode),
        .o_rd     (o_id_rd),
        .o_rs     (o_id_rs),
        .o_rt     (o_id_rt),
        .o_imm8   (w_imm8)
    );

    assign w_ex_taken = i_ex_branch_update[BR_VLD_BIT];
    assign w_accept   = r_valid & i_id_ready;

`ifdef IF_ID_JUMP_EN
    assign w_jmp = w_accept & (w_opcode == OPC_JMP);
`else
    assign w_jmp = 1'b0;
`endif

    // Redirect priority: boot pin, execute redirect, stall replay, early jump.
    // No term depends on i_if_data.
    always_comb begin
        w_br = '0;
        if (r_state == StBoot) begin
            w_br = br_pack(1'b1, RESET_PC);
        end else if (w_ex_taken) begin
            w_br = br_pack(1'b1, i_ex_branch_update[BR_TGT_MSB:BR_TGT_LSB]);
        end else if (r_valid && !i_id_ready) begin
            w_br = br_pack(1'b1, r_pc + 8'd1);
        end else if (w_jmp) begin
            w_br = br_pack(1'b1, w_imm8);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StBoot;
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
        end else begin
            r_state <= StRun;
            if (w_br[BR_VLD_BIT]) begin
                // Fetch is on the wrong path this cycle: never capture if_data.
                // The held instruction survives only a plain stall replay.
                if (w_ex_taken || w_accept) begin
                    r_valid <= 1'b0;
                end
            end else if (!r_valid || i_id_ready) begin
                r_valid <= 1'b1;
                r_pc    <= i_if_data[IF_PC_MSB:IF_PC_LSB];
                r_instr <= i_if_data[IF_INSTR_MSB:IF_INSTR_LSB];
            end
        end
    end

    assign o_branch_update = w_br;
    assign o_id_valid      = r_valid;
    assign o_id_pc         = r_pc;
    assign o_id_opcode     = w_opcode;
    assign o_id_imm8       = w_imm8;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_instruction_decode_stage
// Closes the IF<->ID loop with a behavioural fetch unit over a random program
// memory, drives random ready/execute-redirect stimulus, and scores the stage
// against a program-order model (expected next PC, expected fields, expected
// redirect). Ends with a wrap-around stall at 8'hFF and a mid-stall reset.
// -----------------------------------------------------------------------------
module tb_instruction_decode_stage;

    localparam logic [7:0] RST_PC = 8'h10;
`ifdef IF_ID_JUMP_EN
    localparam bit JMPEN = 1'b1;
`else
    localparam bit JMPEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] if_data;
    logic [8:0]  ex_bu;
    logic [8:0]  bu;
    logic        ready;
    logic        valid;
    logic [7:0]  id_pc;
    logic [3:0]  op, rd, rs, rt;
    logic [7:0]  imm8;

    logic [15:0] imem [256];
    logic [7:0]  f_pc = 8'h00;

    int checks = 0;
    int errors = 0;
    int n_accept = 0;

    // Expected responses to issued execute redirects, popped by the monitor.
    logic [7:0] ex_q [$];

    instruction_decode_stage #(
        .RESET_PC (RST_PC)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_if_data          (if_data),
        .i_ex_branch_update (ex_bu),
        .o_branch_update    (bu),
        .i_id_ready         (ready),
        .o_id_valid         (valid),
        .o_id_pc            (id_pc),
        .o_id_opcode        (op),
        .o_id_rd            (rd),
        .o_id_rs            (rs),
        .o_id_rt            (rt),
        .o_id_imm8          (imm8)
    );

    always #5 clk = ~clk;

    // Fetch unit: follows redirects, otherwise walks sequentially.
    always @(posedge clk) f_pc <= bu[8] ? bu[7:0] : f_pc + 8'd1;
    assign if_data = {imem[f_pc], f_pc};

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor / reference model, sampled 2 time units after the falling edge.
    bit         m_boot = 1'b1;
    bit         m_valid = 1'b0;
    logic [7:0] exp_pc = 8'h00;

    initial begin
        logic       ex;
        logic [7:0] tgt;
        logic [15:0] ci;
        logic [8:0] exp_bu;
        bit         is_jmp;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                chk("reset_branch_update", bu, {1'b1, RST_PC});
                chk("reset_id_valid", valid, 0);
                chk("reset_id_pc", id_pc, 0);
                chk("reset_fields", {op, rd, rs, rt, imm8}, 0);
                m_boot  = 1'b1;
                m_valid = 1'b0;
                ex_q.delete();
            end else begin
                ex  = ex_bu[8];
                tgt = 8'h00;
                if (ex) begin
                    if (ex_q.size() == 0) begin
                        errors++;
                        $display("FAIL ex_queue actual=empty required=entry at %0t", $time);
                    end else begin
                        tgt = ex_q.pop_front();
                    end
                end
                ci     = imem[exp_pc];
                is_jmp = JMPEN && (ci[15:12] == 4'hF);
                if (m_boot)                            exp_bu = {1'b1, RST_PC};
                else if (ex)                           exp_bu = {1'b1, tgt};
                else if (m_valid && !ready)            exp_bu = {1'b1, exp_pc + 8'd1};
                else if (m_valid && ready && is_jmp)   exp_bu = {1'b1, ci[7:0]};
                else                                   exp_bu = 9'h000;

                chk("branch_update", bu, exp_bu);
                chk("id_valid", valid, m_valid);
                if (m_valid) begin
                    chk("id_pc", id_pc, exp_pc);
                    chk("id_opcode", op, ci[15:12]);
                    chk("id_rd", rd, ci[11:8]);
                    chk("id_rs", rs, ci[7:4]);
                    chk("id_rt", rt, ci[3:0]);
                    chk("id_imm8", imm8, ci[7:0]);
                end

                // Program-order model for the next cycle.
                if (m_boot) begin
                    m_boot  = 1'b0;
                    m_valid = 1'b0;
                    exp_pc  = RST_PC;
                end else if (ex) begin
                    m_valid = 1'b0;
                    exp_pc  = tgt;
                end else if (m_valid && ready) begin
                    n_accept++;
                    m_valid = !is_jmp;
                    exp_pc  = is_jmp ? ci[7:0] : exp_pc + 8'd1;
                end else if (!m_valid) begin
                    m_valid = 1'b1;
                end
            end
        end
    end

    // Stimulus.
    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
        rst_n = 1'b0;
        ready = 1'b0;
        ex_bu = 9'h000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ready = ($urandom_range(3) != 0);
            if ($urandom_range(11) == 0) begin
                ex_bu = {1'b1, 8'($urandom)};
                ex_q.push_back(ex_bu[7:0]);
            end else begin
                ex_bu = 9'h000;
            end
        end

        // Force ID to hold 8'hFF under stall, then reset mid-stall.
        @(negedge clk);
        ex_bu = {1'b1, 8'hFF};
        ex_q.push_back(8'hFF);
        ready = 1'b1;
        @(negedge clk);
        ex_bu = 9'h000;
        ready = 1'b0;
        @(negedge clk);
        #3;
        chk("wrap_replay", bu, 9'h100);
        chk("wrap_hold_pc", id_pc, 8'hFF);
        rst_n = 1'b0;
        #1;
        chk("async_valid_drop", valid, 0);
        chk("async_redirect", bu, {1'b1, RST_PC});
        repeat (2) @(negedge clk);
        #4;
        chk("accept_progress", (n_accept > 200), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_decode_stage.md
# instruction_decode_stage

Decode stage that consumes the fetch unit's 24-bit output bundle and returns the 9-bit redirect bundle to it, closing the IF↔ID loop. It holds one instruction in the ID pipeline register, splits it into fields, and presents it downstream with a valid/ready handshake. The fetch unit has no stall or reset input, so this block controls it through redirects alone:
- it re-synchronises fetch after reset;
- it replays the next PC while downstream stalls;
- it forwards execute-stage branch redirects;
- it resolves unconditional jumps early.

## Interface
Parameters:
- RESET_PC, 8'd0, PC that fetch is forced to during and immediately after reset

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_data  in  24  fetch bundle: [7:0] pc, [23:8] instruction
- ex_branch_update  in  9  execute redirect: [8] taken, [7:0] target
- branch_update  out  9  redirect to fetch: [8] redirect, [7:0] target
- id_ready  in  1  downstream accepts the ID instruction this cycle
- id_valid  out  1  ID register holds a valid instruction
- id_pc  out  8  PC of the ID instruction
- id_opcode  out  4  instruction [15:12]
- id_rd  out  4  instruction [11:8]
- id_rs  out  4  instruction [7:4]
- id_rt  out  4  instruction [3:0]
- id_imm8  out  8  instruction [7:0]

One clock; reset is asynchronous and active-low.

## Operation
States: BOOT and RUN. Reset enters BOOT. BOOT moves to RUN after the first clock edge with rst_n high.

Reset values:
- id_valid = 0.
- id_pc and all field outputs = 0.
- branch_update = {1, RESET_PC}, so fetch is pinned at RESET_PC while in reset.

Redirect selection, highest priority first:
1. BOOT: {1, RESET_PC}.
2. ex_branch_update[8]=1: {1, ex_branch_update[7:0]}. The ID register is invalidated at the next edge, even if id_ready=1; the ID instruction is wrong-path.
3. id_valid=1 and id_ready=0 (stall replay): {1, id_pc+1}. Fetch keeps re-presenting the next sequential PC.
4. id_valid=1, id_ready=1, id_opcode=4'hF (JMP, with IF_ID_JUMP_EN): {1, id_imm8}.
5. Otherwise: {0, 8'h00}.

Capture rule:
- In any cycle with branch_update[8]=1, if_data is wrong-path and is discarded.
- Otherwise, the ID register loads if_data when it is empty or when id_ready=1.
- If the ID instruction is accepted while a redirect is active, the ID register empties.

PC arithmetic is 8-bit modulo: id_pc 8'hFF replays 8'h00.

## Timing
- The fetch PC updates on the same edge that samples branch_update, so the redirect target appears on if_data in the following cycle.
- Latency from if_data to id_valid is 1 cycle (registered).
- JMP costs 1 bubble; an execute redirect costs 1 bubble.
- branch_update is combinational from internal registers, ex_branch_update and id_ready only. There is no path from if_data.
- A JMP held under stall emits replay redirects. It emits its jump redirect exactly once, in its accept cycle.
- Reset asserted mid-operation immediately drops id_valid and drives {1, RESET_PC}. In-flight instructions are lost.

## Configuration
- IF_ID_JUMP_EN defined: opcode 4'hF is resolved in ID (priority 4) and still passed downstream with id_valid.
- Not defined: priority 4 is removed. JMP is an ordinary instruction, and execute must redirect via ex_branch_update.

## Structure
- Shared package holds:
  - OPC_JMP = 4'hF;
  - PC_W = 8, INSTR_W = 16, IF_BUNDLE_W = 24, BR_BUNDLE_W = 9;
  - bundle bit-position constants;
  - the state encoding for BOOT/RUN.
- One combinational sub-module, instr_field_decode: it maps the 16-bit instruction to opcode/rd/rs/rt/imm8.
- The stage registers the raw instruction and instantiates instr_field_decode on the register output.

## Test plan
- Reset, then release with RESET_PC=8'h10 → branch_update={1,8'h10} during reset and the first RUN-edge cycle. The next cycle, if_data pc 8'h10 is captured; id_valid=1, id_pc=8'h10.
- Sequential stream pc 0..4 with id_ready=1 → id_pc 0,1,2,3,4 on consecutive cycles; branch_update[8]=0 throughout.
- id_ready=0 for 3 cycles holding id_pc=8'h05 → branch_update={1,8'h06} each cycle and id_pc stays 8'h05. After release, id_pc=8'h06 in the next cycle with no skip or duplicate.
- JMP instr 16'hF040 at pc 8'h02, accepted (IF_ID_JUMP_EN) → branch_update={1,8'h40} for one cycle. Pc 8'h03 is dropped; id_pc=8'h40 two cycles after the JMP.
- ex_branch_update={1,8'h80} while ID holds pc 8'h07 with id_ready=0 → branch_update={1,8'h80} (beats replay). id_valid=0 next cycle, then id_pc=8'h80.
- Stall at id_pc=8'hFF → replay target 8'h00; asserting rst_n=0 mid-stall drops id_valid asynchronously.
